// File: rtl/serial_port_rx_pkg.sv
// Shared definitions for the board serial port: FSM encodings, default line
// settings and the baud divisor rounding used by both receive and transmit sides.
package serial_port_rx_pkg;

  localparam int DEFAULT_BAUD       = 115200;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Receiver FSM encodings, kept as plain 3-bit constants for legacy tools.
  typedef logic [2:0] rx_state_t;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int calc_divisor(input int clk_freq, input int baud,
                                      input int oversample);
    int rate;
    int div;
    rate = baud * oversample;
    div  = (clk_freq + rate / 2) / rate;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/serial_port_rx_if.sv
// CPU-facing and line-facing signals of the serial receiver.
// master = the side that drives the line and pops bytes; slave = the receiver.
interface serial_port_rx_if;

  logic       RxD;
  logic       read_enable;
  logic [7:0] data_out;
  logic       data_available;
  logic       overrun;
  logic       frame_error;
  logic       rx_busy;

  modport master (
    output RxD,
    output read_enable,
    input  data_out,
    input  data_available,
    input  overrun,
    input  frame_error,
    input  rx_busy
  );

  modport slave (
    input  RxD,
    input  read_enable,
    output data_out,
    output data_available,
    output overrun,
    output frame_error,
    output rx_busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator, shared by the UART transmit and
// receive paths. tick is high for one clock each time the counter wraps.
module uart_baud_tick #(
  parameter int DIVISOR = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIVISOR-1 and wrap; never stalls.
  // NOTE: clocked state is always written with <= so every flop samples
  // pre-edge values and simulation matches the synthesised registers.
  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  // With DIVISOR == 1 the counter sits at 0 and tick is high every cycle.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_port_rx.sv
// 8N1 UART receiver: synchronises RxD, finds the start bit by oversampling,
// samples each bit near its centre, and holds one byte for the CPU with a
// valid/read handshake, sticky overrun and a frame-error pulse.
module serial_port_rx
  import serial_port_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic              clk,
  input  logic              rst,
  serial_port_rx_if.slave   bus
);

  localparam int            DIVISOR   = calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int            SW        = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);

  logic          tick;
  logic          rxd_meta;
  logic          rxd_s;
  rx_state_t     state;
  logic [SW-1:0] scnt;
  logic [2:0]    bcnt;
  logic [7:0]    shift_reg;
  logic          stop_sample;
  logic          good_stop;
  logic          rd_ok;
  logic [7:0]    data_q;
  logic          avail_q;
  logic          overrun_q;
  logic          ferr_q;

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= bus.RxD;
      rxd_s    <= rxd_meta;
    end
  end

  assign stop_sample = (state == ST_STOP) && tick && (scnt == BIT_LAST);
  assign good_stop   = stop_sample && rxd_s;
  assign rd_ok       = bus.read_enable && avail_q;

  // Frame FSM: start-bit qualification, LSB-first data capture, stop check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shift_reg <= '0;
      ferr_q    <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state <= ST_START;
            scnt  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (scnt == HALF_LAST) begin
              scnt <= '0;
              bcnt <= '0;
              // A line that is high again at mid start bit was only a glitch.
              state <= rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (scnt == BIT_LAST) begin
              scnt      <= '0;
              shift_reg <= {rxd_s, shift_reg[7:1]};
              bcnt      <= bcnt + 1'b1;
              if (bcnt == 3'd7) state <= ST_STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (stop_sample) begin
            scnt <= '0;
            if (rxd_s) begin
              state <= ST_IDLE;
            end else begin
              ferr_q <= 1'b1;
              state  <= ST_BREAK;
            end
          end else if (tick) begin
            scnt <= scnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // A held-low line stays here so it cannot be mistaken for 0x00 bytes.
          if (rxd_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-entry holding buffer: load, same-cycle pop+load, or drop with overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      avail_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (good_stop) begin
      if (!avail_q || bus.read_enable) begin
        data_q  <= shift_reg;
        avail_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (rd_ok) begin
      avail_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign bus.data_out       = data_q;
  assign bus.data_available = avail_q;
  assign bus.overrun        = overrun_q;
  assign bus.frame_error    = ferr_q;
  assign bus.rx_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_port_rx.sv
// Directed bench for serial_port_rx at DIVISOR=1 (one bit = 16 clocks).
module tb_serial_port_rx;

  localparam int BIT_CLKS = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   fe_count;
  int   avail_rises;
  logic prev_avail;

  serial_port_rx_if bus ();

  serial_port_rx #(
    .CLK_FREQ   (1843200),
    .BAUD       (115200),
    .OVERSAMPLE (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor: counts frame_error cycles and data_available rising edges.
  initial begin
    fe_count    = 0;
    avail_rises = 0;
    prev_avail  = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.frame_error === 1'b1) fe_count++;
    if (bus.data_available === 1'b1 && prev_avail !== 1'b1) avail_rises++;
    prev_avail = bus.data_available;
  end

  // Drive one 8N1 frame (160 clocks) from negedge to negedge; read_enable is
  // pulsed at frame clock read_at (-1 = never). RxD is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int read_at);
    int slot;
    for (int k = 0; k < 10 * BIT_CLKS; k++) begin
      @(negedge clk);
      slot = k / BIT_CLKS;
      if (slot == 0)      bus.RxD = 1'b0;
      else if (slot == 9) bus.RxD = stop_bit;
      else                bus.RxD = b[slot-1];
      bus.read_enable = (k == read_at);
    end
    bus.read_enable = 1'b0;
  endtask

  task automatic pulse_read();
    @(negedge clk);
    bus.read_enable = 1'b1;
    @(negedge clk);
    bus.read_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.RxD = 1'b1;
    bus.read_enable = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
    n_vec++; if (bus.data_available !== 1'b0) begin n_err++; $display("FAIL reset_avail: got %b want 0", bus.data_available); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    n_vec++; if (bus.frame_error !== 1'b0) begin n_err++; $display("FAIL reset_frame_error: got %b want 0", bus.frame_error); end
    n_vec++; if (bus.rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.rx_busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int fe0;
    fe0 = fe_count;
    send_frame(8'hA5, 1'b1, -1);
    repeat (2) @(negedge clk);
    n_vec++; if (bus.data_out !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", bus.data_out); end
    n_vec++; if (bus.data_available !== 1'b1) begin n_err++; $display("FAIL single_avail: got %b want 1", bus.data_available); end
    n_vec++; if (fe_count !== fe0) begin n_err++; $display("FAIL single_no_ferr: got %0d pulses want 0", fe_count - fe0); end
    n_vec++; if (bus.rx_busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b want 0", bus.rx_busy); end
    pulse_read();
    n_vec++; if (bus.data_available !== 1'b0) begin n_err++; $display("FAIL single_read_clear: got %b want 0", bus.data_available); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    repeat (2) @(negedge clk);
    n_vec++; if (bus.data_out !== 8'h3C) begin n_err++; $display("FAIL b2b_data_kept: got %h want 3c", bus.data_out); end
    n_vec++; if (bus.data_available !== 1'b1) begin n_err++; $display("FAIL b2b_avail: got %b want 1", bus.data_available); end
    n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun_set: got %b want 1", bus.overrun); end
    pulse_read();
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun_clear: got %b want 0", bus.overrun); end
    n_vec++; if (bus.data_available !== 1'b0) begin n_err++; $display("FAIL b2b_read_clear: got %b want 0", bus.data_available); end
  endtask

  task automatic test_frame_error();
    int fe0;
    int ar0;
    fe0 = fe_count;
    ar0 = avail_rises;
    send_frame(8'h55, 1'b0, -1);
    repeat (20 * BIT_CLKS) @(negedge clk);
    n_vec++; if (bus.rx_busy !== 1'b1) begin n_err++; $display("FAIL break_busy: got %b want 1", bus.rx_busy); end
    repeat (20 * BIT_CLKS) @(negedge clk);
    n_vec++; if (fe_count !== fe0 + 1) begin n_err++; $display("FAIL ferr_pulse_cycles: got %0d want 1", fe_count - fe0); end
    n_vec++; if (bus.data_available !== 1'b0) begin n_err++; $display("FAIL ferr_no_avail: got %b want 0", bus.data_available); end
    n_vec++; if (avail_rises !== ar0) begin n_err++; $display("FAIL break_no_bytes: got %0d bytes want 0", avail_rises - ar0); end
    bus.RxD = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_vec++; if (bus.rx_busy !== 1'b0) begin n_err++; $display("FAIL break_release: got busy=%b want 0", bus.rx_busy); end
    send_frame(8'h0F, 1'b1, -1);
    repeat (2) @(negedge clk);
    n_vec++; if (bus.data_out !== 8'h0F) begin n_err++; $display("FAIL after_break_data: got %h want 0f", bus.data_out); end
    n_vec++; if (bus.data_available !== 1'b1) begin n_err++; $display("FAIL after_break_avail: got %b want 1", bus.data_available); end
    pulse_read();
  endtask

  task automatic test_glitch();
    int fe0;
    int ar0;
    fe0 = fe_count;
    ar0 = avail_rises;
    @(negedge clk);
    bus.RxD = 1'b0;
    repeat (4) @(negedge clk);
    bus.RxD = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    n_vec++; if (bus.rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got busy=%b want 0", bus.rx_busy); end
    n_vec++; if (avail_rises !== ar0) begin n_err++; $display("FAIL glitch_no_byte: got %0d bytes want 0", avail_rises - ar0); end
    n_vec++; if (fe_count !== fe0) begin n_err++; $display("FAIL glitch_no_ferr: got %0d pulses want 0", fe_count - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    int ar0;
    // 0xFF frame: start bit, bits 0..3, then halfway into bit 4.
    for (int k = 0; k < 5 * BIT_CLKS + 8; k++) begin
      @(negedge clk);
      bus.RxD = (k < BIT_CLKS) ? 1'b0 : 1'b1;
    end
    n_vec++; if (bus.rx_busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy: got %b want 1", bus.rx_busy); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL midrst_data_out: got %h want 00", bus.data_out); end
    n_vec++; if (bus.data_available !== 1'b0) begin n_err++; $display("FAIL midrst_avail: got %b want 0", bus.data_available); end
    n_vec++; if (bus.rx_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.rx_busy); end
    rst = 1'b0;
    ar0 = avail_rises;
    repeat (5 * BIT_CLKS) @(negedge clk);
    n_vec++; if (avail_rises !== ar0) begin n_err++; $display("FAIL midrst_no_partial: got %0d bytes want 0", avail_rises - ar0); end
    send_frame(8'h81, 1'b1, -1);
    repeat (2) @(negedge clk);
    n_vec++; if (bus.data_out !== 8'h81) begin n_err++; $display("FAIL midrst_next_data: got %h want 81", bus.data_out); end
    pulse_read();
  endtask

  task automatic test_pop_and_load();
    int ar0;
    send_frame(8'h11, 1'b1, -1);
    repeat (2) @(negedge clk);
    n_vec++; if (bus.data_out !== 8'h11) begin n_err++; $display("FAIL hold_data: got %h want 11", bus.data_out); end
    ar0 = avail_rises;
    // Stop sample falls on frame clock 155; read_enable set at negedge 154.
    send_frame(8'h22, 1'b1, 154);
    repeat (2) @(negedge clk);
    n_vec++; if (bus.data_out !== 8'h22) begin n_err++; $display("FAIL popload_data: got %h want 22", bus.data_out); end
    n_vec++; if (bus.data_available !== 1'b1) begin n_err++; $display("FAIL popload_avail: got %b want 1", bus.data_available); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL popload_overrun: got %b want 0", bus.overrun); end
    n_vec++; if (avail_rises !== ar0) begin n_err++; $display("FAIL popload_avail_gap: got %0d new rises want 0", avail_rises - ar0); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.RxD = 1'b1;
    bus.read_enable = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_pop_and_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
